// File: rtl/gpio_seq_ctrl.sv
// gpio_seq_ctrl: sequences GPIO direction/data accesses over a single-transfer AHB master port.
// Ports: HCLK/HRESETn, AHB master (HADDR/HTRANS/HWRITE/HSEL/HWDATA out, HREADY/HRDATA/PARITYERR in),
//        cmd_valid/cmd_ready/cmd_write/cmd_wdata in, rsp_valid/rsp_ready/rsp_rdata/rsp_perr out.
// Option: GPIO_SEQ_PERR_RETRY_EN retries a read that saw PARITYERR, up to 3 attempts in total.
module gpio_seq_ctrl #(
    parameter logic [15:0] GPIO_DATA_ADDR = 16'h0000,
    parameter logic [15:0] GPIO_DIR_ADDR  = 16'h0004
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic        HSEL,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic        PARITYERR,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [16:0] rsp_rdata,
    output logic        rsp_perr
);

    typedef enum logic [2:0] {
        IDLE, DIR_A, DIR_D, SETTLE, DATA_A, DATA_D, RESP
    } state_t;

    state_t      state_q, state_d;
    logic        dir_q, dir_d;
    logic        wr_q, wr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [16:0] rdata_q, rdata_d;
    logic        perr_q, perr_d;
`ifdef GPIO_SEQ_PERR_RETRY_EN
    logic [1:0]  retry_q, retry_d;
`endif

    // Only bits [16:0] of the GPIO data register carry information.
    logic unused_hrdata;
    assign unused_hrdata = ^HRDATA[31:17];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            perr_q  <= perr_d;
        end
    end

`ifdef GPIO_SEQ_PERR_RETRY_EN
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            retry_q <= '0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        perr_d  = perr_q;
`ifdef GPIO_SEQ_PERR_RETRY_EN
        retry_d = retry_q;
`endif
        HADDR   = '0;
        HTRANS  = 2'b00;
        HWRITE  = 1'b0;
        HSEL    = 1'b0;
        HWDATA  = '0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    wr_d    = cmd_write;
                    wdata_d = cmd_wdata;
                    // Writes report zero, so clear the response up front.
                    rdata_d = '0;
                    perr_d  = 1'b0;
`ifdef GPIO_SEQ_PERR_RETRY_EN
                    retry_d = '0;
`endif
                    state_d = (cmd_write != dir_q) ? DIR_A : DATA_A;
                end
            end
            DIR_A: begin
                HSEL   = 1'b1;
                HTRANS = 2'b10;
                HWRITE = 1'b1;
                HADDR  = {16'h0000, GPIO_DIR_ADDR};
                if (HREADY) state_d = DIR_D;
            end
            DIR_D: begin
                HWDATA = {31'b0, wr_q};
                if (HREADY) begin
                    dir_d   = wr_q;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                // One idle bus cycle lets the pad direction settle.
                state_d = DATA_A;
            end
            DATA_A: begin
                HSEL   = 1'b1;
                HTRANS = 2'b10;
                HWRITE = wr_q;
                HADDR  = {16'h0000, GPIO_DATA_ADDR};
                if (HREADY) state_d = DATA_D;
            end
            DATA_D: begin
                if (wr_q) HWDATA = {16'h0000, wdata_q};
                if (HREADY) begin
                    if (!wr_q) begin
                        rdata_d = HRDATA[16:0];
                        perr_d  = PARITYERR;
                    end
                    state_d = RESP;
`ifdef GPIO_SEQ_PERR_RETRY_EN
                    if (!wr_q && PARITYERR && retry_q != 2'd2) begin
                        retry_d = retry_q + 2'd1;
                        state_d = DATA_A;
                    end
`endif
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = HRESETn && (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_perr  = perr_q;

endmodule

// File: tb/tb_gpio_seq_ctrl.sv
// tb_gpio_seq_ctrl: directed bench for gpio_seq_ctrl with a response scoreboard and bus log.
// Responses are queued at issue time and popped by an independent monitor.
module tb_gpio_seq_ctrl;

    localparam logic [15:0] DATA_A = 16'h0000;
    localparam logic [15:0] DIR_A  = 16'h0004;

    logic        HCLK;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HSEL;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        PARITYERR;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [16:0] rsp_rdata;
    logic        rsp_perr;

    int compared   = 0;
    int mismatched = 0;

    logic [17:0] sb[$];
    logic [16:0] ap_q[$];
    logic [31:0] wd_q[$];
    logic        dph;
    logic        dph_wr;

    gpio_seq_ctrl #(
        .GPIO_DATA_ADDR(DATA_A),
        .GPIO_DIR_ADDR (DIR_A)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HSEL     (HSEL),
        .HWDATA   (HWDATA),
        .HREADY   (HREADY),
        .HRDATA   (HRDATA),
        .PARITYERR(PARITYERR),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_perr (rsp_perr)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Response monitor: pops one expectation per accepted response.
    always @(negedge HCLK) begin
        if (HRESETn && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                logic [17:0] e;
                e = sb.pop_front();
                chk("rsp_rdata", {15'b0, rsp_rdata}, {15'b0, e[17:1]});
                chk("rsp_perr", {31'b0, rsp_perr}, {31'b0, e[0]});
            end
        end
    end

    // Bus log: completed address phases and write data phases.
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            dph = 1'b0;
        end else begin
            if (dph && HREADY) begin
                if (dph_wr) wd_q.push_back(HWDATA);
                dph = 1'b0;
            end
            if (HSEL && HTRANS == 2'b10 && HREADY) begin
                ap_q.push_back({HWRITE, HADDR[15:0]});
                dph    = 1'b1;
                dph_wr = HWRITE;
            end
        end
    end

    task automatic wait_rsp(inout int n);
        while (n < 60) begin
            @(negedge HCLK);
            if (rsp_valid) break;
            @(posedge HCLK);
            n++;
        end
    endtask

    task automatic do_cmd(input logic wr, input logic [15:0] wd,
                          input int exp_lat, input logic [16:0] erd,
                          input logic eperr, input string nm);
        int n;
        ap_q.delete();
        wd_q.delete();
        sb.push_back({erd, eperr});
        @(posedge HCLK); #1;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_wdata = wd;
        @(negedge HCLK);
        chk({nm, "_cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
        n = 1;
        wait_rsp(n);
        chk({nm, "_latency"}, n, exp_lat);
        @(posedge HCLK); #1;
    endtask

    initial begin
        int n;
        int seen;
        HRESETn   = 1'b0;
        HREADY    = 1'b1;
        HRDATA    = '0;
        PARITYERR = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        #2;
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        chk("rst_hsel", {31'b0, HSEL}, 32'd0);
        chk("rst_htrans", {30'b0, HTRANS}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {15'b0, rsp_rdata}, 32'd0);
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;

        // First write changes direction to output.
        do_cmd(1'b1, 16'hA5A5, 6, 17'h0, 1'b0, "wr1");
        chk("wr1_naddr", ap_q.size(), 2);
        chk("wr1_nwd", wd_q.size(), 2);
        if (ap_q.size() >= 2 && wd_q.size() >= 2) begin
            chk("wr1_dir_ap", {15'b0, ap_q[0]}, {15'b0, 1'b1, DIR_A});
            chk("wr1_dat_ap", {15'b0, ap_q[1]}, {15'b0, 1'b1, DATA_A});
            chk("wr1_dir_wd", wd_q[0], 32'h1);
            chk("wr1_dat_wd", wd_q[1], 32'h0000A5A5);
        end

        // Second write: direction cached.
        do_cmd(1'b1, 16'h0003, 3, 17'h0, 1'b0, "wr2");
        chk("wr2_naddr", ap_q.size(), 1);
        if (wd_q.size() >= 1) chk("wr2_wd", wd_q[0], 32'h3);

        // Read after write: direction back to input.
        HRDATA = 32'hFFFE_0001 & 32'h0001_FFFF | 32'h0001_0000;
        do_cmd(1'b0, 16'h0, 6, 17'h1_0001, 1'b0, "rd1");
        chk("rd1_naddr", ap_q.size(), 2);
        if (ap_q.size() >= 2 && wd_q.size() >= 1) begin
            chk("rd1_dir_wd", wd_q[0], 32'h0);
            chk("rd1_dat_ap", {15'b0, ap_q[1]}, {15'b0, 1'b0, DATA_A});
        end

        // HREADY stall in DATA_A, back-pressured response, ignored busy command.
        ap_q.delete();
        wd_q.delete();
        HRDATA = 32'h0000_1234;
        sb.push_back({17'h0_1234, 1'b0});
        rsp_ready = 1'b0;
        @(posedge HCLK); #1;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        @(posedge HCLK); #1;
        HREADY    = 1'b0;
        cmd_write = 1'b1;
        cmd_wdata = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            chk("stall_hsel", {31'b0, HSEL}, 32'd1);
            chk("stall_haddr", HADDR, {16'h0, DATA_A});
            chk("stall_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            @(posedge HCLK); #1;
        end
        HREADY    = 1'b1;
        cmd_valid = 1'b0;
        n = 4;
        wait_rsp(n);
        chk("stall_latency", n, 6);
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge HCLK);
            chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("bp_rsp_rdata", {15'b0, rsp_rdata}, 32'h1234);
            @(posedge HCLK); #1;
        end
        rsp_ready = 1'b1;
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("stall_naddr", ap_q.size(), 1);
        chk("stall_idle", {31'b0, cmd_ready}, 32'd1);

        // Reset asserted while the direction data phase is in flight.
        @(posedge HCLK); #1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_wdata = 16'h1234;
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("abort_dir_d_wd", HWDATA, 32'h1);
        #1 HRESETn = 1'b0;
        #1;
        chk("abort_hsel", {31'b0, HSEL}, 32'd0);
        chk("abort_htrans", {30'b0, HTRANS}, 32'd0);
        chk("abort_hwdata", HWDATA, 32'd0);
        chk("abort_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge HCLK);
            if (rsp_valid) seen++;
        end
        chk("abort_no_rsp", seen, 0);
        do_cmd(1'b1, 16'h5A5A, 6, 17'h0, 1'b0, "wr3");
        chk("wr3_naddr", ap_q.size(), 2);
        if (ap_q.size() >= 1) chk("wr3_dir_ap", {15'b0, ap_q[0]}, {15'b0, 1'b1, DIR_A});

        // Read with parity error stuck high.
        HRDATA    = 32'h0000_0F0F;
        PARITYERR = 1'b1;
`ifdef GPIO_SEQ_PERR_RETRY_EN
        do_cmd(1'b0, 16'h0, 10, 17'h0_0F0F, 1'b1, "perr");
        chk("perr_naddr", ap_q.size(), 4);
`else
        do_cmd(1'b0, 16'h0, 6, 17'h0_0F0F, 1'b1, "perr");
        chk("perr_naddr", ap_q.size(), 2);
`endif
        PARITYERR = 1'b0;

        repeat (2) @(posedge HCLK);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gpio_seq_ctrl.md
GPIO_SEQ_CTRL -- requirements
Module: gpio_seq_ctrl

Interface
REQ-001 SHALL have parameter GPIO_DATA_ADDR, default 16'h0000, the GPIO data register offset driven on HADDR[15:0].
REQ-002 SHALL have parameter GPIO_DIR_ADDR, default 16'h0004, the GPIO direction register offset driven on HADDR[15:0].
REQ-003 SHALL have ports:
  - HCLK  in  1  clock, all logic on rising edge
  - HRESETn  in  1  reset, asynchronous, active-low
  - HADDR  out  32  AHB address, upper 16 bits 0
  - HTRANS  out  2  2'b10 (NONSEQ) in an address phase, else 2'b00
  - HWRITE  out  1  transfer direction
  - HSEL  out  1  GPIO slave select
  - HWDATA  out  32  write data, upper 16 bits 0
  - HREADY  in  1  bus ready
  - HRDATA  in  32  read data, bits [16:0] used
  - PARITYERR  in  1  GPIO parity error flag
  - cmd_valid / cmd_ready  in / out  1 / 1  command handshake
  - cmd_write  in  1  1 = drive output, 0 = sample input
  - cmd_wdata  in  16  output value
  - rsp_valid / rsp_ready  out / in  1 / 1  response handshake
  - rsp_rdata  out  17  sampled {parity, data}
  - rsp_perr  out  1  PARITYERR captured with rsp_rdata

Function
REQ-004 SHALL use FSM states IDLE, DIR_A, DIR_D, SETTLE, DATA_A, DATA_D, RESP, with one bus transfer outstanding at most.
REQ-005 SHALL assert cmd_ready only in IDLE and accept a command on cmd_valid & cmd_ready.
REQ-006 SHALL keep dir_cache (0 = input, 1 = output), reset 0, matching the GPIO direction reset value.
REQ-007 On accept, SHALL go to DIR_A if cmd_write != dir_cache, else to DATA_A; the command fields are latched.
REQ-008 In DIR_A, SHALL drive HSEL=1, HTRANS=2'b10, HWRITE=1, HADDR=GPIO_DIR_ADDR, and hold until HREADY=1, then go to DIR_D.
REQ-009 In DIR_D, SHALL drive HWDATA={31'b0, cmd_write}; when HREADY=1 it SHALL update dir_cache and go to SETTLE.
REQ-010 SETTLE SHALL last exactly 1 cycle with the bus idle, then go to DATA_A.
REQ-011 In DATA_A, SHALL drive HSEL=1, HTRANS=2'b10, HADDR=GPIO_DATA_ADDR, HWRITE=latched cmd_write, and hold until HREADY=1.
REQ-012 In DATA_D:
  - for a write, SHALL drive HWDATA={16'b0, wdata};
  - for a read, SHALL capture HRDATA[16:0] and PARITYERR into rsp_rdata / rsp_perr when HREADY=1, then go to RESP.
REQ-013 Writes SHALL return rsp_rdata=0 and rsp_perr=0.
REQ-014 In RESP, SHALL assert rsp_valid and hold rsp_rdata / rsp_perr stable until rsp_ready=1, then go to IDLE.
REQ-015 Outside address phases SHALL drive HSEL=0, HTRANS=2'b00, HWRITE=0, HADDR=0; outside write data phases SHALL drive HWDATA=0.
REQ-016 Latency, HREADY=1, rsp_ready=1, accept in cycle 0:
  - no direction change: rsp_valid in cycle 3;
  - with direction change: rsp_valid in cycle 6.
REQ-017 cmd_valid asserted while not in IDLE SHALL be ignored, with no loss of the in-flight command.

Reset
REQ-018 HRESETn low SHALL force all of the following immediately, at any state, including mid-transfer:
  - FSM to IDLE, dir_cache=0;
  - all bus outputs to their REQ-015 idle values;
  - rsp_valid=0, rsp_rdata=0, rsp_perr=0;
  - cmd_ready=0 while reset is asserted.
REQ-019 An in-flight command SHALL be dropped on reset with no response.

Configuration
REQ-020 With GPIO_SEQ_PERR_RETRY_EN defined:
  - a read capturing PARITYERR=1 SHALL re-enter DATA_A, up to 2 retries (3 attempts total);
  - the response SHALL carry the last attempt's data and flag.
REQ-021 Without GPIO_SEQ_PERR_RETRY_EN, every read SHALL make exactly one attempt.

Verification
REQ-022 Reset, then cmd_write=1, wdata=16'hA5A5 -> DIR write of 1, SETTLE, DATA write with HWDATA=32'h0000A5A5, rsp_valid in cycle 6, rsp_perr=0.
REQ-023 Second write, wdata=16'h0003 -> no DIR transfer, rsp_valid in cycle 3.
REQ-024 Read after write, GPIOIN=17'h1_0001 (even parity, PARITYSEL=0) -> DIR write of 0, rsp_rdata=17'h1_0001, rsp_perr=0.
REQ-025 HREADY held low 3 cycles in DATA_A, then rsp_ready held low 2 cycles -> address held, rsp_valid and data stable until accepted.
REQ-026 HRESETn low during DIR_D -> bus idle immediately, no rsp_valid, next write performs the DIR transfer.
REQ-027 With GPIO_SEQ_PERR_RETRY_EN, PARITYERR stuck at 1 on a read -> exactly 3 read transfers, rsp_perr=1; without the macro -> 1 transfer, rsp_perr=1.
